// File: rtl/axi_pkg.sv
// Shared AXI definitions for the bridge: ID layout, response and burst codes,
// and the write-responder state encoding.
package axi_pkg;

  localparam int ID_S_BITS  = 8;
  localparam int MIDX_MSB   = 5;
  localparam int MIDX_LSB   = 4;
  localparam int MID_BITS   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_RESP  = 2'd2
  } wresp_state_t;

  // Bursts this slave cannot service: beats wider than one word, WRAP, or reserved.
  function automatic logic burst_unsupported(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd2) || (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_wbeat_addr_gen.sv
// Per-beat address and beat counter for one write burst; flags the last beat
// and length mismatches. Length checking is enabled by WRESP_ERR_CHECK_EN.
module axi_wbeat_addr_gen #(
  parameter int ADDR_BITS     = 32,
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_BITS-1:0]     aw_addr,
  input  logic [3:0]               aw_len,
  input  logic [2:0]               aw_size,
  input  logic [1:0]               aw_burst,
  input  logic                     beat,
  input  logic                     wlast,
  output logic [MEM_ADDR_BITS-1:0] word_addr,
  output logic                     last_beat,
  output logic                     len_err
);
  import axi_pkg::*;

  logic [ADDR_BITS-1:0] cur_addr;
  logic [ADDR_BITS-1:0] step;
  logic [3:0]           len_q;
  logic [3:0]           beat_cnt;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic                 cnt_done;

  assign step      = {{(ADDR_BITS-1){1'b0}}, 1'b1} << size_q;
  assign word_addr = cur_addr[MEM_ADDR_BITS+1:2];
  assign cnt_done  = (beat_cnt == len_q);

`ifdef WRESP_ERR_CHECK_EN
  assign last_beat = wlast || cnt_done;
  assign len_err   = (wlast && (beat_cnt < len_q)) || (cnt_done && !wlast);
`else
  // WLAST is not trusted here: the burst length comes from AWLEN alone.
  logic unused_wlast;
  assign unused_wlast = wlast;
  assign last_beat    = cnt_done;
  assign len_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      size_q   <= '0;
      burst_q  <= '0;
    end else if (start) begin
      cur_addr <= aw_addr;
      len_q    <= aw_len;
      beat_cnt <= '0;
      size_q   <= aw_size;
      burst_q  <= aw_burst;
    end else if (beat) begin
      // WRAP is walked like INCR; when it is unsupported its writes are suppressed anyway.
      if (burst_q != BURST_FIXED)
        cur_addr <= cur_addr + step;
      if (!last_beat)
        beat_cnt <= beat_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/axi_slave_wresp.sv
// Slave-end AW/W/B responder: one burst at a time into a word-wide memory port.
// Optional error checking and SLVERR responses are enabled by WRESP_ERR_CHECK_EN.
module axi_slave_wresp #(
  parameter int ID_S_BITS     = 8,
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_S_BITS-1:0]     AWID_S,
  input  logic [ADDR_BITS-1:0]     AWADDR,
  input  logic [3:0]               AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_BITS-1:0]     WDATA,
  input  logic [DATA_BITS/8-1:0]   WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [ID_S_BITS-1:0]     BID_S,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic                     mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0]     mem_wdata,
  output logic [DATA_BITS/8-1:0]   mem_wstrb
);
  import axi_pkg::*;

  wresp_state_t         state, state_next;
  logic                 aw_hs, w_hs;
  logic                 last_beat, len_err, proto_err;
  logic                 err, suppress;
  logic [ID_S_BITS-1:0] bid_q;

  // Handshake readiness comes from the state alone, never from the VALIDs.
  assign AWREADY = (state == S_IDLE);
  assign WREADY  = (state == S_WDATA);
  assign BVALID  = (state == S_RESP);
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;

`ifdef WRESP_ERR_CHECK_EN
  assign proto_err = burst_unsupported(AWSIZE, AWBURST);
`else
  assign proto_err = 1'b0;
`endif

  axi_wbeat_addr_gen #(
    .ADDR_BITS     (ADDR_BITS),
    .MEM_ADDR_BITS (MEM_ADDR_BITS)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (aw_hs),
    .aw_addr   (AWADDR),
    .aw_len    (AWLEN),
    .aw_size   (AWSIZE),
    .aw_burst  (AWBURST),
    .beat      (w_hs),
    .wlast     (WLAST),
    .word_addr (mem_addr),
    .last_beat (last_beat),
    .len_err   (len_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (aw_hs) state_next = S_WDATA;
      S_WDATA: if (w_hs && last_beat) state_next = S_RESP;
      S_RESP:  if (BREADY) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Protocol errors are known at AW time; length errors accumulate beat by beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bid_q    <= '0;
      err      <= 1'b0;
      suppress <= 1'b0;
    end else if (aw_hs) begin
      bid_q    <= AWID_S;
      err      <= proto_err;
      suppress <= proto_err;
    end else if (w_hs && len_err) begin
      err      <= 1'b1;
    end
  end

  assign BID_S     = bid_q;
  assign BRESP     = (BVALID && err) ? RESP_SLVERR : RESP_OKAY;
  assign mem_we    = w_hs && !suppress;
  assign mem_wdata = WREADY ? WDATA : '0;
  assign mem_wstrb = WREADY ? WSTRB : '0;

endmodule
